conv_complex_mac: RTL
=====================

Name: conv_complex_mac

Overview:
Parametrised, sequential successor to the fixed 3-tap complex convolver. It computes the full linear convolution of an N-element complex signal with a K-tap complex kernel in signed QI.QF fixed point. The datapath is a single time-multiplexed complex MAC, driven by a start/busy/done handshake, with saturation and a sticky overflow flag. It sits in the same signal-processing path and consumes the same packed kernel/signal buses.

Parameters:
QI, 4, integer bits incl. sign, per real/imag part
QF, 4, fractional bits per part; W = QI+QF
NUM_ELEMS, 3, signal length N (>=1)
NUM_TAPS, 3, kernel length K (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  clock enable; when 0, all state holds
start  in  1  single-cycle request; sampled only in IDLE with en=1
kernel  in  2*W*K  tap k at [2W*k +: 2W]; real part in upper W bits, imag in lower W bits
signal  in  2*W*N  element i at [2W*i +: 2W], same re/im packing
conv  out  2*W*(N+K-1)  result element n at [2W*n +: 2W], same packing
busy  out  1  high in MAC/STORE
done  out  1  one-cycle pulse when results are valid
overflow  out  1  sticky; any part saturated during the current run

Behaviour:
- Reset (rst=0, async): state=IDLE; conv=0; busy=0; done=0; overflow=0; counters n and k =0.
- Let M = N+K-1. Accumulator width is A = 2W+1+clog2(K)+1, signed.
- IDLE: on an edge with en=1 and start=1:
  - latch kernel and signal into internal registers (input buses may change afterwards);
  - clear conv, overflow, accumulators, n and k;
  - go to MAC.
- MAC, one tap per cycle: if 0 <= n-k < N, then acc_re += kr*sr - ki*si and acc_im += kr*si + ki*sr, with s = signal[n-k]; otherwise add 0. If k=K-1, go to STORE; else k++.
- STORE:
  - each part = acc >>> QF (arithmetic shift, floor), then saturate to [-2^(W-1), 2^(W-1)-1];
  - write the result to conv slot n;
  - if any part clipped, set overflow (sticky);
  - clear accumulators and k;
  - if n=M-1, go to DONE; else n++ and go to MAC.
- DONE: done=1 for exactly one cycle, then IDLE. conv and overflow hold until the next accepted start.
- Latency: done rises M*(K+1)+1 enabled edges after the start edge (Q4.4, N=K=3: 21).
- start while busy or in DONE is ignored; it is not queued.
- en=0 freezes the FSM, counters, accumulators and outputs, including a pending done pulse, which stays high until the next enabled edge.
- Reset mid-run aborts immediately to reset values; no partial done.
- Products are full-precision 2W-bit (2QF fractional bits) and sign-extended into A bits. The accumulator never wraps for any K.

Optional Feature:
CONV_ROUND_EN
- Defined: STORE computes (acc + 2^(QF-1)) >>> QF (round half toward +inf) before saturation; the rounding add is done in A+1 bits.
- Undefined: plain floor truncation as above.
- Latency and all other behaviour are identical.

Test Plan:
- Defaults, kernel tap0=0x10/0x00 (1+0j), other taps 0, signal={1.0625+0j, -2.0+0j, -0.375+1.25j} → conv = signal elements followed by two zero slots; overflow=0; done pulse 21 edges after start; busy high for 20 cycles.
- Kernel tap0=0x00/0x10 (0+1j), signal[0]=0x10/0x00 → conv[0]=0x00/0x10; tap1=0x20/0x00 (2.0) → conv[1]=0x20/0x00.
- Saturation: signal[0]=0x70 (7.0) real, tap0=0x20 (2.0) → conv[0].re=0x7F, overflow=1; signal[0]=0x80 (-8.0) → 0x80, overflow=1. Next clean run clears overflow to 0.
- Rounding: 0x01*0x08 (0.0625*0.5) → 0x00 without the macro, 0x01 with it; 0xFF*0x08 → 0xFF without, 0x00 with.
- Handshake: start pulsed again mid-run → ignored, single done; en=0 for 5 cycles mid-run → done delayed exactly 5 cycles, results unchanged.
- rst low mid-run → conv=0, busy=0, done=0, overflow=0 immediately; a fresh start then completes normally.

Source files
------------

// File: rtl/conv_complex_mac.sv
// conv_complex_mac: sequential complex linear convolution on one time-multiplexed MAC; define CONV_ROUND_EN for round-half-up output
module conv_complex_mac #(
  parameter int QI = 4,
  parameter int QF = 4,
  parameter int NUM_ELEMS = 3,
  parameter int NUM_TAPS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic start,
  input  logic [2*(QI+QF)*NUM_TAPS-1:0] kernel,
  input  logic [2*(QI+QF)*NUM_ELEMS-1:0] signal,
  output logic [2*(QI+QF)*(NUM_ELEMS+NUM_TAPS-1)-1:0] conv,
  output logic busy,
  output logic done,
  output logic overflow
);
  localparam int W = QI + QF;
  localparam int N = NUM_ELEMS;
  localparam int K = NUM_TAPS;
  localparam int M = N + K - 1;
  localparam int A = 2*W + 1 + $clog2(K) + 1;
  localparam int NW = $clog2(M + 1);
  localparam int KW = $clog2(K + 1);
  localparam int SW = $clog2(N + 1);
  localparam logic signed [A:0] hi = {{(A+2-W){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [A:0] lo = {{(A+2-W){1'b1}}, {(W-1){1'b0}}};
`ifdef CONV_ROUND_EN
  localparam logic signed [A:0] rnd = (A+1)'(2**(QF-1));
`endif

  typedef enum logic [1:0] {st_idle, st_mac, st_store, st_done} state_t;

  state_t state, state_d;
  logic [2*W*K-1:0] kern_q;
  logic [2*W*N-1:0] sig_q;
  logic [2*W*M-1:0] conv_q;
  logic signed [A-1:0] acc_re, acc_im, t_re, t_im;
  logic [NW-1:0] n;
  logic [KW-1:0] k;
  logic [SW-1:0] sel;
  logic hit, ovf, done_q;
  int d;
  logic signed [W-1:0] kr, ki, sr, si;
  logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [W:0] f_re, f_im;

  function automatic logic signed [A-1:0] sx(input logic signed [2*W-1:0] p);
    return {{(A-2*W){p[2*W-1]}}, p};
  endfunction

  // returns {clipped, value}; the extra bit keeps the rounding add from wrapping
  function automatic logic [W:0] fix(input logic signed [A-1:0] a);
    logic signed [A:0] v;
    v = {a[A-1], a};
`ifdef CONV_ROUND_EN
    v = v + rnd;
`endif
    v = v >>> QF;
    return v > hi ? {1'b1, hi[W-1:0]} : v < lo ? {1'b1, lo[W-1:0]} : {1'b0, v[W-1:0]};
  endfunction

  always_comb begin
    d = int'(n) - int'(k);
    hit = d >= 0 && d < N;
    sel = hit ? SW'(d) : '0;
    kr = kern_q[2*W*k+W +: W];
    ki = kern_q[2*W*k +: W];
    sr = hit ? sig_q[2*W*sel+W +: W] : '0;
    si = hit ? sig_q[2*W*sel +: W] : '0;
    p_rr = (2*W)'(kr) * (2*W)'(sr);
    p_ii = (2*W)'(ki) * (2*W)'(si);
    p_ri = (2*W)'(kr) * (2*W)'(si);
    p_ir = (2*W)'(ki) * (2*W)'(sr);
    t_re = sx(p_rr) - sx(p_ii);
    t_im = sx(p_ri) + sx(p_ir);
    f_re = fix(acc_re);
    f_im = fix(acc_im);
  end

  always_comb begin
    state_d = state;
    case (state)
      st_idle:  state_d = start ? st_mac : st_idle;
      st_mac:   state_d = k == KW'(K-1) ? st_store : st_mac;
      st_store: state_d = n == NW'(M-1) ? st_done : st_mac;
      default:  state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= st_idle;
    else if (en) state <= state_d;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      kern_q <= '0;
      sig_q <= '0;
      conv_q <= '0;
      acc_re <= '0;
      acc_im <= '0;
      n <= '0;
      k <= '0;
      ovf <= 1'b0;
      done_q <= 1'b0;
    end else if (en) begin
      done_q <= state == st_done;
      if (state == st_idle && start) begin
        kern_q <= kernel;
        sig_q <= signal;
        conv_q <= '0;
        ovf <= 1'b0;
        acc_re <= '0;
        acc_im <= '0;
        n <= '0;
        k <= '0;
      end else if (state == st_mac) begin
        acc_re <= acc_re + t_re;
        acc_im <= acc_im + t_im;
        k <= k == KW'(K-1) ? k : k + KW'(1);
      end else if (state == st_store) begin
        conv_q[2*W*n +: 2*W] <= {f_re[W-1:0], f_im[W-1:0]};
        ovf <= ovf | f_re[W] | f_im[W];
        acc_re <= '0;
        acc_im <= '0;
        k <= '0;
        n <= n == NW'(M-1) ? n : n + NW'(1);
      end
    end

  assign conv = conv_q;
  assign busy = state == st_mac || state == st_store;
  assign done = done_q;
  assign overflow = ovf;
endmodule
